// File: rtl/std_cache_pkg.sv
// Shared data-cache types and constants used by the cache port arbiter.
package std_cache_pkg;
  localparam int unsigned DCACHE_SET_ASSOC   = 4;
  localparam int unsigned DCACHE_INDEX_WIDTH = 8;
  localparam int unsigned DCACHE_TAG_WIDTH   = 12;
  localparam int unsigned DCACHE_LINE_WIDTH  = 64;
  // Port ids live in a fixed 3-bit field, so at most 8 requesters.
  localparam int unsigned DCACHE_PORT_W      = 3;

  localparam int unsigned SNOOP_PORT = 0;
  localparam int unsigned MISS_PORT  = 1;

  typedef logic [DCACHE_LINE_WIDTH-1:0]   cache_line_t;
  typedef logic [DCACHE_LINE_WIDTH/8-1:0] cl_be_t;
  typedef logic [DCACHE_PORT_W-1:0]       port_id_t;

  typedef struct packed {
    logic     valid;
    port_id_t id;
  } rd_port_t;
endpackage

// File: rtl/dcache_port_arbiter_rr.sv
// Round-robin picker: grants the first request at or after ptr_i, wrapping.
module dcache_port_arbiter_rr
  import std_cache_pkg::*;
#(
  parameter int unsigned NR_REQ = 2
) (
  input  logic [NR_REQ-1:0] req_i,
  input  port_id_t          ptr_i,
  output logic [NR_REQ-1:0] gnt_o,
  output logic              vld_o
);

  always_comb begin
    gnt_o = '0;
    vld_o = 1'b0;
    for (int off = 0; off < int'(NR_REQ); off++) begin
      for (int k = 0; k < int'(NR_REQ); k++) begin
        if (!vld_o && req_i[k] && (k == (int'(ptr_i) + off) % int'(NR_REQ))) begin
          gnt_o[k] = 1'b1;
          vld_o    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Data-cache SRAM port arbiter: fixed priority for low ports, round-robin for the
// rest, with lockable ownership bounded by LOCK_MAX and one-cycle read tracking.
module dcache_port_arbiter
  import std_cache_pkg::*;
#(
  parameter int unsigned NR_PORTS = 4,
  parameter int unsigned NR_FIXED = 2,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic [NR_PORTS-1:0][DCACHE_SET_ASSOC-1:0]    req_i,
  input  logic [NR_PORTS-1:0]                          lock_i,
  input  logic [NR_PORTS-1:0][DCACHE_INDEX_WIDTH-1:0]  addr_i,
  input  logic [NR_PORTS-1:0][DCACHE_TAG_WIDTH-1:0]    tag_i,
  input  logic [NR_PORTS-1:0]                          we_i,
  input  cl_be_t [NR_PORTS-1:0]                        be_i,
  input  cache_line_t [NR_PORTS-1:0]                   data_i,
  output logic [NR_PORTS-1:0]                          gnt_o,
  output logic [NR_PORTS-1:0]                          rvalid_o,
  output logic [DCACHE_SET_ASSOC-1:0]                  hit_way_o,
  output logic [DCACHE_SET_ASSOC-1:0]                  sram_req_o,
  output logic [DCACHE_INDEX_WIDTH-1:0]                sram_addr_o,
  output logic                                         sram_we_o,
  output cl_be_t                                       sram_be_o,
  output cache_line_t                                  sram_data_o,
  output logic [DCACHE_TAG_WIDTH-1:0]                  sram_tag_o,
  input  logic [DCACHE_SET_ASSOC-1:0]                  hit_way_i,
  output logic                                         updating_cache_o
);

  localparam int unsigned NR_RR = NR_PORTS - NR_FIXED;
  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  rd_port_t         owner_q, owner_d, rd_port_q, rd_port_d, tag_port_q, tag_port_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  port_id_t         rr_ptr_q, rr_ptr_d, gnt_id;

  logic [NR_PORTS-1:0] port_req, owner_oh, arb_req, fixed_gnt, gnt;
  logic [NR_RR-1:0]    rr_gnt;
  logic                rr_vld, owner_hold, forced, gnt_lock;

  // Requests are masked while in reset so every output reads zero.
  always_comb begin
    for (int i = 0; i < int'(NR_PORTS); i++) begin
      port_req[i] = rst_ni && (|req_i[i]);
      owner_oh[i] = owner_q.valid && (owner_q.id == port_id_t'(i));
    end
  end

  assign owner_hold = |(owner_oh & port_req & lock_i);
  assign forced     = owner_hold && (lock_cnt_q == CNT_W'(LOCK_MAX));
  assign arb_req    = forced ? (port_req & ~owner_oh) : port_req;

  always_comb begin
    fixed_gnt = '0;
    for (int i = int'(NR_FIXED) - 1; i >= 0; i--) begin
      if (arb_req[i]) begin
        fixed_gnt    = '0;
        fixed_gnt[i] = 1'b1;
      end
    end
  end

  dcache_port_arbiter_rr #(
    .NR_REQ (NR_RR)
  ) i_rr (
    .req_i (arb_req[NR_PORTS-1:NR_FIXED]),
    .ptr_i (rr_ptr_q - port_id_t'(NR_FIXED)),
    .gnt_o (rr_gnt),
    .vld_o (rr_vld)
  );

  // A forced-out owner still gets the port back when nobody else wants it.
  always_comb begin
    gnt = '0;
    if (owner_hold && !forced)   gnt = owner_oh;
    else if (|fixed_gnt)         gnt = fixed_gnt;
    else if (rr_vld)             gnt[NR_PORTS-1:NR_FIXED] = rr_gnt;
    else if (forced)             gnt = owner_oh;
  end

  assign gnt_o     = gnt;
  assign gnt_lock  = |(gnt & lock_i);
  assign sram_we_o = |(gnt & we_i);

  always_comb begin
    sram_req_o  = '0;
    sram_addr_o = '0;
    sram_be_o   = '0;
    sram_data_o = '0;
    sram_tag_o  = '0;
    rvalid_o    = '0;
    gnt_id      = '0;
    for (int i = 0; i < int'(NR_PORTS); i++) begin
      if (gnt[i]) begin
        sram_req_o  = req_i[i];
        sram_addr_o = addr_i[i];
        sram_be_o   = be_i[i];
        sram_data_o = data_i[i];
        gnt_id      = port_id_t'(i);
      end
      if (tag_port_q.valid && (tag_port_q.id == port_id_t'(i))) sram_tag_o = tag_i[i];
      rvalid_o[i] = rd_port_q.valid && (rd_port_q.id == port_id_t'(i));
    end
  end

  assign hit_way_o        = rd_port_q.valid ? hit_way_i : '0;
  assign updating_cache_o = owner_q.valid && (owner_q.id != port_id_t'(SNOOP_PORT));

  always_comb begin
    owner_d    = gnt_lock ? {1'b1, gnt_id} : '0;
    rd_port_d  = {(|gnt) && !sram_we_o, gnt_id};
    tag_port_d = {(|gnt), gnt_id};

    if (forced)          lock_cnt_d = '0;
    else if (owner_hold) lock_cnt_d = lock_cnt_q + CNT_W'(1);
    else if (gnt_lock)   lock_cnt_d = CNT_W'(1);
    else                 lock_cnt_d = '0;

    rr_ptr_d = rr_ptr_q;
    if (|gnt[NR_PORTS-1:NR_FIXED]) begin
      rr_ptr_d = (gnt_id == port_id_t'(NR_PORTS - 1)) ? port_id_t'(NR_FIXED)
                                                      : gnt_id + port_id_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q    <= '0;
      rd_port_q  <= '0;
      tag_port_q <= '0;
      lock_cnt_q <= '0;
      rr_ptr_q   <= port_id_t'(NR_FIXED);
    end else begin
      owner_q    <= owner_d;
      rd_port_q  <= rd_port_d;
      tag_port_q <= tag_port_d;
      lock_cnt_q <= lock_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Scoreboard bench for dcache_port_arbiter: a port-level reference model queues the
// expected grant/mux/read results, and a negedge monitor compares them.
module tb_dcache_port_arbiter;
  import std_cache_pkg::*;

  localparam int NP = 4;
  localparam int NF = 2;
  localparam int LM = 16;
  localparam int SA = DCACHE_SET_ASSOC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NP-1:0][SA-1:0]                 req;
  logic [NP-1:0]                         lock, we;
  logic [NP-1:0][DCACHE_INDEX_WIDTH-1:0] addr;
  logic [NP-1:0][DCACHE_TAG_WIDTH-1:0]   tag;
  cl_be_t [NP-1:0]                       be;
  cache_line_t [NP-1:0]                  data;
  logic [SA-1:0]                         hit_in, hit_out, s_req;
  logic [NP-1:0]                         gnt, rvalid;
  logic [DCACHE_INDEX_WIDTH-1:0]         s_addr;
  logic                                  s_we, upd;
  cl_be_t                                s_be;
  cache_line_t                           s_data;
  logic [DCACHE_TAG_WIDTH-1:0]           s_tag;

  dcache_port_arbiter #(.NR_PORTS(NP), .NR_FIXED(NF), .LOCK_MAX(LM)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .lock_i(lock), .addr_i(addr),
    .tag_i(tag), .we_i(we), .be_i(be), .data_i(data), .gnt_o(gnt),
    .rvalid_o(rvalid), .hit_way_o(hit_out), .sram_req_o(s_req),
    .sram_addr_o(s_addr), .sram_we_o(s_we), .sram_be_o(s_be),
    .sram_data_o(s_data), .sram_tag_o(s_tag), .hit_way_i(hit_in),
    .updating_cache_o(upd)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                            cyc;
    logic [NP-1:0]                 gnt;
    logic [SA-1:0]                 sreq;
    logic [DCACHE_INDEX_WIDTH-1:0] addr;
    logic                          we;
    cl_be_t                        be;
    cache_line_t                   data;
    logic [DCACHE_TAG_WIDTH-1:0]   tag;
    logic                          upd;
  } exp_t;

  typedef struct {
    int                          cyc;
    int                          port;
    logic [DCACHE_TAG_WIDTH-1:0] tag;
    logic [SA-1:0]               hit;
  } rd_exp_t;

  exp_t    gq[$];
  rd_exp_t rq[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // reference model state: owner port (-1 none), owned-cycle count, rr pointer,
  // last granted port and last read port (-1 none)
  int m_owner = -1, m_cnt = 0, m_rr = NF, m_prev = -1, m_prev_rd = -1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic idle();
    req = '0; lock = '0; we = '0;
  endtask

  task automatic rand_data();
    for (int p = 0; p < NP; p++) begin
      addr[p] = DCACHE_INDEX_WIDTH'($urandom);
      tag[p]  = DCACHE_TAG_WIDTH'($urandom);
      be[p]   = cl_be_t'($urandom);
      data[p] = cache_line_t'({$urandom, $urandom});
    end
    hit_in = SA'($urandom);
  endtask

  // Runs one clock cycle with the inputs already driven; eg/erv/eupd < 0 skip the
  // directed checks of gnt_o / rvalid_o / updating_cache_o for this cycle.
  task automatic step(input string nm, input int eg, input int erv, input int eupd);
    exp_t    e;
    rd_exp_t r;
    bit      pr[NP];
    bit      cand[NP];
    bit      hold, frc;
    int      g;
    if (!rst_n) begin
      m_owner = -1; m_cnt = 0; m_rr = NF; m_prev = -1; m_prev_rd = -1;
    end
    for (int i = 0; i < NP; i++) pr[i] = rst_n && (req[i] != '0);
    hold = (m_owner >= 0) && pr[m_owner] && lock[m_owner];
    frc  = hold && (m_cnt == LM);
    cand = pr;
    if (frc) cand[m_owner] = 1'b0;
    g = -1;
    if (hold && !frc) g = m_owner;
    else begin
      for (int i = 0; i < NF; i++) if (g < 0 && cand[i]) g = i;
      for (int k = 0; k < NP - NF; k++) begin
        int p = NF + (m_rr - NF + k) % (NP - NF);
        if (g < 0 && cand[p]) g = p;
      end
      if (g < 0 && frc) g = m_owner;
    end

    e.cyc  = cyc;
    e.gnt  = (g >= 0) ? NP'(1 << g) : '0;
    e.sreq = (g >= 0) ? req[g] : '0;
    e.addr = (g >= 0) ? addr[g] : '0;
    e.we   = (g >= 0) ? we[g] : 1'b0;
    e.be   = (g >= 0) ? be[g] : '0;
    e.data = (g >= 0) ? data[g] : '0;
    e.tag  = (m_prev >= 0) ? tag[m_prev] : '0;
    e.upd  = (m_owner > 0);
    gq.push_back(e);
    if (m_prev_rd >= 0) begin
      r.cyc = cyc; r.port = m_prev_rd; r.tag = tag[m_prev_rd]; r.hit = hit_in;
      rq.push_back(r);
    end

    if (rst_n) begin
      if (frc)                     m_cnt = 0;
      else if (hold)               m_cnt = m_cnt + 1;
      else if (g >= 0 && lock[g])  m_cnt = 1;
      else                         m_cnt = 0;
      m_owner = (g >= 0 && lock[g]) ? g : -1;
      if (g >= NF) m_rr = (g == NP - 1) ? NF : g + 1;
      m_prev    = g;
      m_prev_rd = (g >= 0 && !we[g]) ? g : -1;
    end

    #2;
    if (eg >= 0)   chk({nm, " gnt_o"}, 64'(gnt), 64'(eg));
    if (erv >= 0)  chk({nm, " rvalid_o"}, 64'(rvalid), 64'(erv));
    if (eupd >= 0) chk({nm, " updating_cache_o"}, 64'(upd), 64'(eupd));
    @(posedge clk); #1;
    cyc++;
  endtask

  always @(negedge clk) begin
    exp_t    e;
    rd_exp_t r;
    if (gq.size() > 0) begin
      e = gq.pop_front();
      chk("gnt", 64'(gnt), 64'(e.gnt));
      chk("sram_req", 64'(s_req), 64'(e.sreq));
      chk("sram_addr", 64'(s_addr), 64'(e.addr));
      chk("sram_we", 64'(s_we), 64'(e.we));
      chk("sram_be", 64'(s_be), 64'(e.be));
      chk("sram_data", s_data, e.data);
      chk("sram_tag", 64'(s_tag), 64'(e.tag));
      chk("updating_cache", 64'(upd), 64'(e.upd));
      if (rvalid != '0) begin
        if (rq.size() == 0) chk("rvalid_unexpected", 64'(rvalid), 64'(0));
        else begin
          r = rq.pop_front();
          chk("rvalid_cycle", 64'(e.cyc), 64'(r.cyc));
          chk("rvalid_port", 64'(rvalid), 64'(1 << r.port));
          chk("rvalid_tag", 64'(s_tag), 64'(r.tag));
          chk("rvalid_hit_way", 64'(hit_out), 64'(r.hit));
        end
      end else begin
        chk("hit_way_idle", 64'(hit_out), 64'(0));
        if (rq.size() > 0 && rq[0].cyc <= e.cyc) begin
          r = rq.pop_front();
          chk("rvalid_missing", 64'(rvalid), 64'(1 << r.port));
        end
      end
    end
  end

  initial begin
    idle();
    rand_data();
    @(posedge clk); #1;
    step("reset", 0, 0, 0);
    step("reset", 0, 0, 0);
    rst_n = 1'b1;

    // snoop port beats a round-robin port; read result the next cycle
    rand_data(); req[0] = 4'b0011; req[2] = 4'b0100;
    step("fixed_vs_rr", 4'b0001, 0, 0);
    rand_data(); idle();
    step("read_return", 0, 4'b0001, 0);

    // round-robin alternation between ports 2 and 3
    for (int k = 0; k < 4; k++) begin
      rand_data(); idle(); req[2] = 4'b0001; req[3] = 4'b1000;
      step("rr_alt", (k % 2 == 0) ? 4'b0100 : 4'b1000, -1, -1);
    end
    idle(); step("gap", 0, -1, 0);

    // port 2 locks; snoop waits until the owner is forced out after LOCK_MAX
    rand_data(); idle(); req[2] = 4'b0010; lock[2] = 1'b1;
    step("lock_first", 4'b0100, -1, 0);
    for (int k = 2; k <= 17; k++) begin
      rand_data(); req[0] = 4'b0001;
      step("lock_hold", (k < 17) ? 4'b0100 : 4'b0001, -1, 1);
    end
    rand_data(); idle();
    step("lock_end", 0, -1, 0);

    // miss handler locked, then releases while port 3 is waiting
    rand_data(); idle(); req[MISS_PORT] = 4'b0001; lock[MISS_PORT] = 1'b1;
    step("miss_lock", 4'b0010, -1, 0);
    rand_data(); req[3] = 4'b0100;
    step("miss_hold", 4'b0010, -1, 1);
    rand_data(); req[MISS_PORT] = '0; lock[MISS_PORT] = 1'b0;
    step("miss_release", 4'b1000, -1, 1);
    rand_data(); idle();
    step("miss_after", 0, -1, 0);

    // write then read back-to-back: only the read returns rvalid
    rand_data(); idle(); req[2] = 4'b0001; we[2] = 1'b1;
    step("wr", 4'b0100, 0, -1);
    rand_data(); idle(); req[3] = 4'b0010;
    step("rd_after_wr", 4'b1000, 4'b0000, -1);
    rand_data(); idle();
    step("rd_return", 0, 4'b1000, -1);

    // reset in the middle of a port-3 lock
    rand_data(); idle(); req[3] = 4'b0001; lock[3] = 1'b1;
    step("p3_lock", 4'b1000, -1, 0);
    rand_data();
    step("p3_hold", 4'b1000, 4'b1000, 1);
    rand_data(); req[0] = 4'b0001; rst_n = 1'b0;
    step("rst_mid_lock", 0, 0, 0);
    rand_data(); rst_n = 1'b1;
    step("post_rst", 4'b0001, 0, 0);

    // randomized traffic with sticky requests so locks run long enough to expire
    idle();
    for (int c = 0; c < 3000; c++) begin
      rand_data();
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, (lock[p] && req[p] != '0) ? 7 : 3) == 0) begin
          req[p]  = ($urandom_range(0, 2) == 0) ? '0 : SA'($urandom);
          lock[p] = ($urandom_range(0, 3) == 0);
          we[p]   = ($urandom_range(0, 1) == 1);
        end
      end
      rst_n = ($urandom_range(0, 499) != 0);
      step("rand", -1, -1, -1);
    end
    rst_n = 1'b1;
    idle();
    for (int c = 0; c < 3; c++) begin
      rand_data();
      step("drain", 0, -1, -1);
    end
    chk("gq_drain", 64'(gq.size()), 64'(0));
    chk("rq_drain", 64'(rq.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
